// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter sharing one constant source among N_INPUTS token-only channels.
// The winner's index and a valid flag are held in a one-entry output register.
module handshake_constant_arbiter #(
  parameter int          N_INPUTS    = 4,
  parameter int          DATA_WIDTH  = 32,
  parameter int unsigned CONST_VALUE = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_INPUTS-1:0]   ins_valid,
  output logic [N_INPUTS-1:0]   ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [((N_INPUTS > 1) ? $clog2(N_INPUTS) : 1)-1:0] outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int INDEX_WIDTH = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(N_INPUTS - 1);

  logic                   full;
  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic                   any_valid;
  logic                   load_en;
  logic                   transfer;

  assign any_valid = |ins_valid;
  assign load_en   = !full || outs_ready;
  assign transfer  = load_en && any_valid;

  // Scan requesters starting at ptr and wrapping; the first valid one wins.
  always_comb begin
    int cand;
    logic found;
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_INPUTS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_INPUTS) cand = cand - N_INPUTS;
      if (!found && ins_valid[cand]) begin
        found     = 1'b1;
        grant_idx = INDEX_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    ins_ready = '0;
    if (transfer && !rst) ins_ready[grant_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      ptr   <= '0;
      idx_q <= '0;
    end else if (transfer) begin
      full  <= 1'b1;
      idx_q <= grant_idx;
      ptr   <= (grant_idx == LAST_INDEX) ? '0 : grant_idx + 1'b1;
    end else if (outs_ready) begin
      full <= 1'b0;
    end
  end

  assign outs       = DATA_WIDTH'(CONST_VALUE);
  assign outs_valid = full;
  assign outs_index = idx_q;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed and randomized checks of a 4-input and a 3-input arbiter driven side by side
// against a rotation-order reference model.
module tb_handshake_constant_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        outs_ready;
  logic [3:0]  v4, rdy4;
  logic [2:0]  v3, rdy3;
  logic [31:0] outs4, outs3;
  logic [1:0]  idx4, idx3;
  logic        ov4, ov3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  handshake_constant_arbiter #(.N_INPUTS(4), .DATA_WIDTH(32), .CONST_VALUE(30)) dut4 (
    .clk(clk), .rst(rst), .ins_valid(v4), .ins_ready(rdy4), .outs(outs4),
    .outs_index(idx4), .outs_valid(ov4), .outs_ready(outs_ready)
  );

  handshake_constant_arbiter #(.N_INPUTS(3), .DATA_WIDTH(32), .CONST_VALUE(30)) dut3 (
    .clk(clk), .rst(rst), .ins_valid(v3), .ins_ready(rdy3), .outs(outs3),
    .outs_index(idx3), .outs_valid(ov3), .outs_ready(outs_ready)
  );

  typedef struct {
    int n;
    bit full;
    int idx;
    int ptr;
  } model_t;

  model_t m4, m3;

  // First requester in the order ptr, ptr+1, ... modulo n; -1 when none.
  function automatic int pick(model_t m, logic [3:0] v);
    for (int k = 0; k < m.n; k++) begin
      int i = (m.ptr + k) % m.n;
      if (v[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(model_t m, logic [3:0] v, logic r, logic rs);
    int g = pick(m, v);
    if (rs || (m.full && !r) || g < 0) return 4'b0000;
    return 4'(1) << g;
  endfunction

  function automatic model_t advance(model_t m, logic [3:0] v, logic r, logic rs);
    model_t nm = m;
    int g = pick(m, v);
    if (rs) begin
      nm.full = 1'b0;
      nm.idx  = 0;
      nm.ptr  = 0;
    end else if ((!m.full || r) && g >= 0) begin
      nm.full = 1'b1;
      nm.idx  = g;
      nm.ptr  = (g + 1) % m.n;
    end else if (r) begin
      nm.full = 1'b0;
    end
    return nm;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag, input model_t m, input logic [3:0] v,
                             input logic [3:0] rdy, input logic ov, input logic [1:0] idx,
                             input logic [31:0] o);
    check({tag, "_ready"}, 32'(rdy), 32'(exp_ready(m, v, outs_ready, rst)));
    check({tag, "_valid"}, 32'(ov), 32'(m.full));
    check({tag, "_index"}, 32'(idx), 32'(m.idx));
    check({tag, "_outs"}, o, 32'd30);
  endtask

  // Drive inputs, let them settle, and compare every output with the model.
  task automatic apply(input logic [3:0] a4, input logic [2:0] a3, input logic r, input logic rs);
    v4 = a4;
    v3 = a3;
    outs_ready = r;
    rst = rs;
    #1;
    check_model("m4", m4, v4, rdy4, ov4, idx4, outs4);
    check_model("m3", m3, {1'b0, v3}, {1'b0, rdy3}, ov3, idx3, outs3);
  endtask

  task automatic tick();
    @(posedge clk);
    m4 = advance(m4, v4, outs_ready, rst);
    m3 = advance(m3, {1'b0, v3}, outs_ready, rst);
    #1;
  endtask

  initial begin
    m4 = '{n: 4, full: 1'b0, idx: 0, ptr: 0};
    m3 = '{n: 3, full: 1'b0, idx: 0, ptr: 0};
    v4 = 4'b1111;
    v3 = 3'b111;
    outs_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: reset held with every requester active
    apply(4'b1111, 3'b111, 1'b1, 1'b1);
    check("t1_ready_in_reset", 32'(rdy4), 32'd0);
    tick();
    apply(4'b1111, 3'b111, 1'b1, 1'b1);
    tick();
    check("t1_valid_after_reset", 32'(ov4), 32'd0);
    apply(4'b1111, 3'b111, 1'b1, 1'b0);
    check("t1_first_grant4", 32'(rdy4), 32'b0001);
    check("t1_first_grant3", 32'(rdy3), 32'b001);
    tick();
    check("t1_first_index", 32'(idx4), 32'd0);

    // T2: single requester, then the slot drains
    apply(4'b0000, 3'b000, 1'b1, 1'b0);
    tick();
    apply(4'b0100, 3'b000, 1'b1, 1'b0);
    tick();
    check("t2_valid", 32'(ov4), 32'd1);
    check("t2_outs", outs4, 32'd30);
    check("t2_index", 32'(idx4), 32'd2);
    apply(4'b0000, 3'b000, 1'b1, 1'b0);
    tick();
    check("t2_drained", 32'(ov4), 32'd0);

    // T3: all requesting from a fresh pointer, no bubbles; 3-input sequence alongside
    apply(4'b0000, 3'b000, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      apply(4'b1111, 3'b111, 1'b1, 1'b0);
      tick();
      check("t3_valid", 32'(ov4), 32'd1);
      check("t3_index4", 32'(idx4), 32'(i % 4));
      if (i < 4) check("t3_index3", 32'(idx3), 32'(i % 3));
    end

    // T4: backpressure holds the token, then drain and load on one edge
    for (int i = 0; i < 5; i++) begin
      apply(4'b0011, 3'b000, 1'b0, 1'b0);
      check("t4_stall_ready", 32'(rdy4), 32'd0);
      tick();
      check("t4_stall_index", 32'(idx4), 32'd1);
      check("t4_stall_valid", 32'(ov4), 32'd1);
    end
    apply(4'b0011, 3'b000, 1'b1, 1'b0);
    check("t4_release_ready", 32'(rdy4), 32'b0001);
    tick();
    check("t4_reload_valid", 32'(ov4), 32'd1);
    check("t4_reload_index", 32'(idx4), 32'd0);

    // T5: wrap and skip around the pointer
    apply(4'b0100, 3'b000, 1'b1, 1'b0);
    tick();
    apply(4'b0010, 3'b000, 1'b1, 1'b0);
    check("t5_skip_ready", 32'(rdy4), 32'b0010);
    tick();
    apply(4'b1001, 3'b000, 1'b1, 1'b0);
    check("t5_wrap_ready", 32'(rdy4), 32'b1000);
    tick();
    check("t5_wrap_index", 32'(idx4), 32'd3);
    apply(4'b1111, 3'b000, 1'b1, 1'b0);
    check("t5_ptr_zero", 32'(rdy4), 32'b0001);
    tick();

    // T6: reset while a token is stalled
    apply(4'b0000, 3'b000, 1'b0, 1'b1);
    tick();
    check("t6_valid4", 32'(ov4), 32'd0);
    check("t6_valid3", 32'(ov3), 32'd0);
    apply(4'b1111, 3'b111, 1'b1, 1'b0);
    check("t6_ptr_reset", 32'(rdy4), 32'b0001);
    tick();

    // Randomized traffic with occasional backpressure and resets
    for (int i = 0; i < 400; i++) begin
      apply(4'($urandom), 3'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      tick();
    end
    apply(4'b0000, 3'b000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
